// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry, valid/ready on both
// sides, flush loads a zero-control bubble that carries a rewound PC.
module pipe_stage_reg #(
   parameter int unsigned     DATA_W   = 128,
   parameter int unsigned     CTRL_W   = 24,
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] PC_RESET = PC_W'(32'h8000_0000),
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_bubble,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   occ_e              state, state_n;
   logic              in_ready_n;
   logic              out_valid_n;
   logic [PC_W-1:0]   main_pc_n;
   logic [DATA_W-1:0] main_data_n;
   logic [CTRL_W-1:0] main_ctrl_n;
   logic              main_bub_n;
   logic [PC_W-1:0]   skid_pc, skid_pc_n;
   logic [DATA_W-1:0] skid_data, skid_data_n;
   logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
   logic              skid_bub, skid_bub_n;
   logic              accept;
   logic              emit;

   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;
   assign occupancy = 2'(state);

   // State, main (output) and skid registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= OCC_EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_pc     <= PC_RESET;
         out_data   <= '0;
         out_ctrl   <= '0;
         out_bubble <= 1'b0;
         skid_pc    <= '0;
         skid_data  <= '0;
         skid_ctrl  <= '0;
         skid_bub   <= 1'b0;
      end else begin
         state      <= state_n;
         in_ready   <= in_ready_n;
         out_valid  <= out_valid_n;
         out_pc     <= main_pc_n;
         out_data   <= main_data_n;
         out_ctrl   <= main_ctrl_n;
         out_bubble <= main_bub_n;
         skid_pc    <= skid_pc_n;
         skid_data  <= skid_data_n;
         skid_ctrl  <= skid_ctrl_n;
         skid_bub   <= skid_bub_n;
      end
   end

   // Occupancy transitions and entry movement; flush overrides everything.
   always_comb begin
      state_n     = state;
      main_pc_n   = out_pc;
      main_data_n = out_data;
      main_ctrl_n = out_ctrl;
      main_bub_n  = out_bubble;
      skid_pc_n   = skid_pc;
      skid_data_n = skid_data;
      skid_ctrl_n = skid_ctrl;
      skid_bub_n  = skid_bub;

      if (flush) begin
         // Held and incoming entries are dropped; the PC rewinds to the
         // address of the instruction being flushed when one is presented.
         state_n     = OCC_ONE;
         main_data_n = '0;
         main_ctrl_n = '0;
         main_bub_n  = 1'b1;
         if (in_valid) main_pc_n = in_pc - PC_W'(PC_STEP);
         skid_pc_n   = '0;
         skid_data_n = '0;
         skid_ctrl_n = '0;
         skid_bub_n  = 1'b0;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  state_n     = OCC_ONE;
                  main_pc_n   = in_pc;
                  main_data_n = in_data;
                  main_ctrl_n = in_ctrl;
                  main_bub_n  = 1'b0;
               end
            end
            OCC_ONE: begin
               if (accept && emit) begin
                  main_pc_n   = in_pc;
                  main_data_n = in_data;
                  main_ctrl_n = in_ctrl;
                  main_bub_n  = 1'b0;
               end else if (accept) begin
                  state_n     = OCC_TWO;
                  skid_pc_n   = in_pc;
                  skid_data_n = in_data;
                  skid_ctrl_n = in_ctrl;
                  skid_bub_n  = 1'b0;
               end else if (emit) begin
                  state_n = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (emit) begin
                  state_n     = OCC_ONE;
                  main_pc_n   = skid_pc;
                  main_data_n = skid_data;
                  main_ctrl_n = skid_ctrl;
                  main_bub_n  = skid_bub;
               end
            end
            default: state_n = OCC_EMPTY;
         endcase
      end

      out_valid_n = (state_n != OCC_EMPTY);
      in_ready_n  = (state_n != OCC_TWO);
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register, the general successor to the fixed ID/EX latch. It carries a PC, a datapath payload and a control bundle between two CPU pipeline stages. Upstream and downstream use valid/ready handshakes, and a two-entry skid buffer gives full throughput under back-pressure. A flush replaces the stage contents with a zero-control bubble that keeps a rewound PC, so interrupt entry can recover the flushed instruction's address.

## Interface
- DATA_W, 128: payload width (operands, immediates, register indices); zeroed in bubbles
- CTRL_W, 24: control-bundle width (RegWrite, MemWrite, ALUFun, ...); zeroed in bubbles
- PC_W, 32: PC width
- PC_RESET, 32'h8000_0000: out_pc value after reset
- PC_STEP, 4: amount subtracted from the incoming PC when a bubble is built
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all held and incoming entries and load a bubble
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry; driven from a register
- in_pc  in  PC_W  upstream PC (PC+4 convention)
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  output entry present
- out_ready  in  1  downstream accepts the output entry
- out_pc  out  PC_W  output PC
- out_data  out  DATA_W  output payload
- out_ctrl  out  CTRL_W  output control bundle
- out_bubble  out  1  output entry was created by a flush
- occupancy  out  2  number of entries held (0, 1 or 2)

## Operation
- Storage: a main register drives the out_* ports. A skid register holds one overflow entry.
- Accept condition: an input is accepted when `in_valid & in_ready`. Emit condition: an output is taken when `out_valid & out_ready`.
- Occupancy transitions when flush is low:
  - 0 + accept: the entry loads into main; occupancy becomes 1.
  - 1 + accept + emit: the entry loads into main; occupancy stays 1.
  - 1 + accept, no emit: the entry loads into skid; occupancy becomes 2.
  - 1 + emit only: occupancy becomes 0.
  - 2 + emit: skid moves to main; occupancy becomes 1.
- At occupancy 2, in_ready is 0, so no accept can occur.
- in_ready is registered: it is 1 in the next cycle exactly when the next occupancy is below 2.
- Flush (highest priority):
  - At the clock edge, main and skid contents are discarded, including an unaccepted main entry.
  - An input accepted in the same cycle is consumed and dropped.
  - Main loads a bubble:
    - out_valid=1 and out_bubble=1.
    - out_data=0 and out_ctrl=0.
    - out_pc = in_pc − PC_STEP (mod 2^PC_WIDTH) if in_valid was 1, otherwise out_pc keeps its value.
  - Occupancy becomes 1 and in_ready becomes 1.
- A bubble is an ordinary entry after creation: it drains on out_ready and can be skid-buffered. out_bubble travels with its entry.
- Normal entries carry out_bubble=0.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid=0, out_bubble=0, occupancy=0, in_ready=1.
  - out_pc=PC_RESET, out_data=0, out_ctrl=0.
  - The skid register is cleared.

## Timing
- Latency: 1 cycle from accept to out_valid when the stage was empty or emitting.
- Throughput: 1 entry per cycle while out_ready stays high.
- Holding: while `out_valid & ~out_ready`, all out_* signals are held stable.
- Back-pressure: in_ready deasserts in the cycle after occupancy reaches 2. It reasserts in the cycle after the emit that frees the skid register.
- Flush: the bubble appears on the outputs in the cycle after flush is sampled high. in_ready is 1 in that cycle.
- Flush together with reset: reset wins.
- Paths: no combinational path from any input to any output.

## Test plan
- Streaming, out_ready=1:
  - Stimulus: entries with in_pc 0x80000004, 0x80000008, 0x8000000C on consecutive cycles.
  - Required: each entry appears on out_* one cycle later, in order; occupancy stays 1; in_ready stays 1.
- Back-pressure:
  - Stimulus: hold out_ready=0 while sending A then B.
  - Required: occupancy goes 1 then 2; in_ready=0 the cycle after B; A stays stable on the outputs.
  - Release out_ready=1. Required: A emits, then B; in_ready=1 again the cycle after A emits.
- Flush with input:
  - Stimulus: flush=1 with in_valid=1, in_pc=0x80000010, in_ctrl nonzero, occupancy 2.
  - Required next cycle: out_valid=1, out_bubble=1, out_ctrl=0, out_data=0, out_pc=0x8000000C, occupancy=1, in_ready=1.
- Flush without input:
  - Stimulus: flush=1 with in_valid=0.
  - Required: a bubble with out_pc unchanged from its prior value.
- Stalled bubble:
  - Stimulus: a bubble created while out_ready=0, followed by a normal entry.
  - Required: the bubble holds until out_ready=1; the next entry has out_bubble=0.
- Reset mid-stream:
  - Stimulus: assert reset asynchronously at occupancy 2.
  - Required immediately (no clock edge needed): out_valid=0, out_pc=0x80000000, occupancy=0, in_ready=1.
  - After release: a fresh entry passes with 1-cycle latency.
